// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register offsets, window size,
// arming FSM states and the bank-count helper.
package gpio_pkg;

  // Size of the bus address window claimed by one GPIO port
  localparam int WINDOW_SIZE = 16;

  // Register offsets from the port base address
  localparam logic [3:0] OFF_DIR0     = 4'h0;
  localparam logic [3:0] OFF_DATA0    = 4'h1;
  localparam logic [3:0] OFF_DIR1     = 4'h2;
  localparam logic [3:0] OFF_DATA1    = 4'h3;
  localparam logic [3:0] OFF_RISE_EN0 = 4'h4;
  localparam logic [3:0] OFF_FALL_EN0 = 4'h5;
  localparam logic [3:0] OFF_RISE_EN1 = 4'h6;
  localparam logic [3:0] OFF_FALL_EN1 = 4'h7;
  localparam logic [3:0] OFF_FLAG0    = 4'h8;
  localparam logic [3:0] OFF_FLAG1    = 4'h9;

  // Edge detection is held off until the synchronisers hold real pin data
  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_e;

  // Number of 8-bit register banks needed to cover num_pins pins
  function automatic int bank_count(input int num_pins);
    return (num_pins + 7) / 8;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with a history flop and qualified edge detect.
// edge_set is combinational and is registered into the flag by the parent.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  input  logic armed,
  input  logic dir,
  input  logic rise_en,
  input  logic fall_en,
  output logic sync_level,
  output logic edge_set
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   dir_q;

  // Shift the raw pin through the synchroniser, keep one cycle of history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop see pre-edge values, so the chain advances one stage per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      dir_q  <= dir;
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];

  // Only input pins report edges; dir_q blanks the cycle right after a pin
  // turns from output to input so a stale prev value cannot fake an edge.
  assign edge_set = armed & ~dir & ~dir_q &
                    ((rise_en & sync_level & ~prev_q) |
                     (fall_en & ~sync_level & prev_q));

endmodule

// File: rtl/gpio_port.sv
// General-purpose I/O port on the CPU register bus: direction and output
// latch per pin, synchronised inputs, edge-triggered W1C flags and an irq
// pulse when any flag newly sets.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int          NUM_PINS    = 8,
  parameter logic [23:0] BASE_ADDR   = 24'h2060,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_write,
  input  logic                bus_read,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  output logic [7:0]          bus_data_out,
  output logic                bus_hit,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

  localparam int         NUM_BANKS = bank_count(NUM_PINS);
  localparam logic [2:0] ARM_LAST  = 3'(SYNC_STAGES);

  logic [23:0]         rel_addr;
  logic [3:0]          offset;
  logic                wr_en;

  logic [NUM_PINS-1:0] dir_q, data_q, rise_en_q, fall_en_q, flag_q;
  logic [NUM_PINS-1:0] dir_we, data_we, rise_we, fall_we, flag_clr;
  logic [NUM_PINS-1:0] wr_bits;
  logic [NUM_PINS-1:0] sync_level, edge_set, data_rd;
  logic                irq_q;

  arm_state_e          arm_state;
  logic [2:0]          arm_cnt;
  logic                armed;

  logic [15:0]         dir_w, data_w, rise_w, fall_w, flag_w;
  logic [7:0]          rd_data;

  // Window decode: the subtraction wraps, so addresses below the base miss
  assign rel_addr = bus_address_in - BASE_ADDR;
  assign bus_hit  = (rel_addr < 24'(WINDOW_SIZE));
  assign offset   = rel_addr[3:0];
  assign wr_en    = bus_write & bus_hit;

  // Per-pin write enables; pins beyond NUM_PINS simply have no enable
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can leave a value held, which would infer a latch.
    dir_we   = '0;
    data_we  = '0;
    rise_we  = '0;
    fall_we  = '0;
    flag_clr = '0;
    wr_bits  = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      wr_bits[i]  = bus_data_in[i % 8];
      dir_we[i]   = wr_en && (offset == ((i < 8) ? OFF_DIR0     : OFF_DIR1));
      data_we[i]  = wr_en && (offset == ((i < 8) ? OFF_DATA0    : OFF_DATA1));
      rise_we[i]  = wr_en && (offset == ((i < 8) ? OFF_RISE_EN0 : OFF_RISE_EN1));
      fall_we[i]  = wr_en && (offset == ((i < 8) ? OFF_FALL_EN0 : OFF_FALL_EN1));
      flag_clr[i] = wr_en && (offset == ((i < 8) ? OFF_FLAG0    : OFF_FLAG1))
                    && bus_data_in[i % 8];
    end
  end

  // Control registers, flags and the irq pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q     <= '0;
      data_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flag_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (dir_we[i])  dir_q[i]     <= wr_bits[i];
        if (data_we[i]) data_q[i]    <= wr_bits[i];
        if (rise_we[i]) rise_en_q[i] <= wr_bits[i];
        if (fall_we[i]) fall_en_q[i] <= wr_bits[i];
      end
      // A new edge beats a same-cycle W1C of that bit
      flag_q <= (flag_q & ~flag_clr) | edge_set;
      // Pulse only for bits that were clear before this edge
      irq_q  <= |(edge_set & ~flag_q);
    end
  end

  // Arming FSM: hold edge detection off for SYNC_STAGES+1 cycles after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_state <= DISARMED;
      arm_cnt   <= '0;
    end else begin
      case (arm_state)
        DISARMED: begin
          if (arm_cnt == ARM_LAST) arm_state <= ARMED;
          else                     arm_cnt   <= arm_cnt + 3'd1;
        end
        ARMED:    arm_state <= ARMED;
        default:  arm_state <= DISARMED;
      endcase
    end
  end

  assign armed = (arm_state == ARMED);

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk       (clk),
      .reset     (reset),
      .pin_in    (pin_in[g]),
      .armed     (armed),
      .dir       (dir_q[g]),
      .rise_en   (rise_en_q[g]),
      .fall_en   (fall_en_q[g]),
      .sync_level(sync_level[g]),
      .edge_set  (edge_set[g])
    );
  end

  // Output pins read back their latch, input pins their synchronised level
  assign data_rd = (dir_q & data_q) | (~dir_q & sync_level);

  assign dir_w  = 16'(dir_q);
  assign data_w = 16'(data_rd);
  assign rise_w = 16'(rise_en_q);
  assign fall_w = 16'(fall_en_q);
  assign flag_w = 16'(flag_q);

  // Read mux: zero unless strobed and the offset is implemented
  always_comb begin
    rd_data = 8'h00;
    if (bus_read && bus_hit) begin
      case (offset)
        OFF_DIR0:     rd_data = dir_w[7:0];
        OFF_DATA0:    rd_data = data_w[7:0];
        OFF_RISE_EN0: rd_data = rise_w[7:0];
        OFF_FALL_EN0: rd_data = fall_w[7:0];
        OFF_FLAG0:    rd_data = flag_w[7:0];
        OFF_DIR1:     rd_data = (NUM_BANKS > 1) ? dir_w[15:8]  : 8'h00;
        OFF_DATA1:    rd_data = (NUM_BANKS > 1) ? data_w[15:8] : 8'h00;
        OFF_RISE_EN1: rd_data = (NUM_BANKS > 1) ? rise_w[15:8] : 8'h00;
        OFF_FALL_EN1: rd_data = (NUM_BANKS > 1) ? fall_w[15:8] : 8'h00;
        OFF_FLAG1:    rd_data = (NUM_BANKS > 1) ? flag_w[15:8] : 8'h00;
        default:      rd_data = 8'h00;
      endcase
    end
  end

  assign bus_data_out = rd_data;
  assign pin_out      = data_q;
  assign pin_oe       = dir_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed testbench for gpio_port: an 8-pin and a 12-pin instance share
// the bus; each has its own pins. Inputs change on the falling edge and
// outputs are sampled there too, away from the rising edge.
module tb_gpio_port;

  localparam logic [23:0] BASE = 24'h2060;

  logic        clk;
  logic        reset;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address;
  logic [7:0]  bus_wdata;

  logic [7:0]  rdata8, rdata12;
  logic        hit8, hit12;
  logic [7:0]  pin8, pout8, poe8;
  logic [11:0] pin12, pout12, poe12;
  logic        irq8, irq12;

  int checks;
  int errors;

  gpio_port #(.NUM_PINS(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_address), .bus_data_in(bus_wdata),
    .bus_data_out(rdata8), .bus_hit(hit8),
    .pin_in(pin8), .pin_out(pout8), .pin_oe(poe8), .irq(irq8)
  );

  gpio_port #(.NUM_PINS(12), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_address), .bus_data_in(bus_wdata),
    .bus_data_out(rdata12), .bus_hit(hit12),
    .pin_in(pin12), .pin_out(pout12), .pin_oe(poe12), .irq(irq12)
  );

  always #5 clk = ~clk;

  // Reset both ports; returns just after release, before any rising edge
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One bus write; returns on the falling edge after the commit edge
  task automatic bus_wr(input logic [3:0] off, input logic [7:0] d);
    @(negedge clk);
    bus_address = BASE + 24'(off);
    bus_wdata   = d;
    bus_write   = 1'b1;
    @(negedge clk);
    bus_write   = 1'b0;
  endtask

  // Combinational read of both ports, no clock edge consumed
  task automatic rd(input logic [3:0] off, output logic [7:0] d8, output logic [7:0] d12);
    bus_address = BASE + 24'(off);
    bus_read    = 1'b1;
    #1;
    d8  = rdata8;
    d12 = rdata12;
    bus_read = 1'b0;
    #1;
  endtask

  task automatic test_reset_and_rw();
    logic [7:0] v8, v12;
    pin8 = 8'h0F;
    pin12 = '0;
    do_reset();
    checks++; if (pout8 !== 8'h00) begin errors++; $display("FAIL reset_pin_out: got %h expected 00", pout8); end
    checks++; if (poe8 !== 8'h00) begin errors++; $display("FAIL reset_pin_oe: got %h expected 00", poe8); end
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq8); end
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL reset_data0: got %h expected 00", v8); end

    bus_wr(gpio_pkg::OFF_DIR0, 8'hF0);
    bus_wr(gpio_pkg::OFF_DATA0, 8'hA5);
    checks++; if (poe8 !== 8'hF0) begin errors++; $display("FAIL rw_pin_oe: got %h expected f0", poe8); end
    checks++; if (pout8 !== 8'hA5) begin errors++; $display("FAIL rw_pin_out: got %h expected a5", pout8); end
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'hAF) begin errors++; $display("FAIL rw_data0_read: got %h expected af", v8); end
    rd(gpio_pkg::OFF_DIR0, v8, v12);
    checks++; if (v8 !== 8'hF0) begin errors++; $display("FAIL rw_dir0_read: got %h expected f0", v8); end
    rd(4'hA, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL rw_off_a_read: got %h expected 00", v8); end

    bus_address = 24'h2070; #1;
    checks++; if (hit8 !== 1'b0) begin errors++; $display("FAIL hit_2070: got %b expected 0", hit8); end
    bus_address = 24'h206F; #1;
    checks++; if (hit8 !== 1'b1) begin errors++; $display("FAIL hit_206f: got %b expected 1", hit8); end
    bus_address = 24'h205F; #1;
    checks++; if (hit8 !== 1'b0) begin errors++; $display("FAIL hit_205f: got %b expected 0", hit8); end
    bus_address = BASE + 24'(gpio_pkg::OFF_DATA0); #1;
    checks++; if (hit8 !== 1'b1) begin errors++; $display("FAIL hit_no_strobe: got %b expected 1", hit8); end
    checks++; if (rdata8 !== 8'h00) begin errors++; $display("FAIL read_no_strobe: got %h expected 00", rdata8); end
  endtask

  task automatic test_rise_irq();
    logic [7:0] v8, v12;
    pin8 = 8'h00;
    do_reset();
    repeat (5) @(negedge clk);
    bus_wr(gpio_pkg::OFF_RISE_EN0, 8'h01);
    pin8 = 8'h01;
    @(negedge clk);
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL rise_data_clk1: got %h expected 00", v8); end
    @(negedge clk);
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'h01) begin errors++; $display("FAIL rise_data_clk2: got %h expected 01", v8); end
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL rise_irq_clk2: got %b expected 0", irq8); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL rise_flag_clk2: got %h expected 00", v8); end
    @(negedge clk);
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL rise_irq_clk3: got %b expected 1", irq8); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h01) begin errors++; $display("FAIL rise_flag_clk3: got %h expected 01", v8); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL rise_irq_after[%0d]: got %b expected 0", i, irq8); end
    end
  endtask

  task automatic test_w1c_collision();
    logic [7:0] v8, v12;
    pin8 = 8'h00;
    do_reset();
    repeat (5) @(negedge clk);
    bus_wr(gpio_pkg::OFF_FALL_EN0, 8'h02);
    bus_wr(gpio_pkg::OFF_RISE_EN0, 8'h01);
    pin8 = 8'h01;
    repeat (4) @(negedge clk);
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h01) begin errors++; $display("FAIL w1c_setup_flag: got %h expected 01", v8); end
    pin8 = 8'h03;
    repeat (4) @(negedge clk);
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h01) begin errors++; $display("FAIL w1c_no_rise_bit1: got %h expected 01", v8); end
    pin8 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL w1c_irq_before: got %b expected 0", irq8); end
    bus_address = BASE + 24'(gpio_pkg::OFF_FLAG0);
    bus_wdata   = 8'h03;
    bus_write   = 1'b1;
    @(negedge clk);
    bus_write   = 1'b0;
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL w1c_irq_pulse: got %b expected 1", irq8); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h02) begin errors++; $display("FAIL w1c_flag: got %h expected 02", v8); end
    @(negedge clk);
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL w1c_irq_after: got %b expected 0", irq8); end
  endtask

  task automatic test_arming();
    logic [7:0] v8, v12;
    int irq_seen;
    pin8 = 8'hFF;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset       = 1'b1;
    bus_address = BASE + 24'(gpio_pkg::OFF_RISE_EN0);
    bus_wdata   = 8'hFF;
    bus_write   = 1'b1;
    @(negedge clk);
    bus_write   = 1'b0;
    irq_seen    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq8 !== 1'b0) irq_seen++;
    end
    checks++; if (irq_seen != 0) begin errors++; $display("FAIL arm_irq: got %0d pulses expected 0", irq_seen); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL arm_flag: got %h expected 00", v8); end
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'hFF) begin errors++; $display("FAIL arm_data: got %h expected ff", v8); end
    rd(gpio_pkg::OFF_RISE_EN0, v8, v12);
    checks++; if (v8 !== 8'hFF) begin errors++; $display("FAIL arm_rise_en: got %h expected ff", v8); end
  endtask

  task automatic test_output_pin();
    logic [7:0] v8, v12;
    int irq_seen;
    pin8 = 8'h00;
    do_reset();
    bus_wr(gpio_pkg::OFF_DIR0, 8'h01);
    bus_wr(gpio_pkg::OFF_RISE_EN0, 8'h01);
    bus_wr(gpio_pkg::OFF_FALL_EN0, 8'h01);
    irq_seen = 0;
    pin8 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq8 !== 1'b0) irq_seen++;
    end
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL out_data_latch: got %h expected 00", v8); end
    bus_wr(gpio_pkg::OFF_DIR0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq8 !== 1'b0) irq_seen++;
    end
    rd(gpio_pkg::OFF_DATA0, v8, v12);
    checks++; if (v8 !== 8'h01) begin errors++; $display("FAIL out_to_in_data: got %h expected 01", v8); end
    checks++; if (irq_seen != 0) begin errors++; $display("FAIL out_irq: got %0d pulses expected 0", irq_seen); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL out_flag: got %h expected 00", v8); end
  endtask

  task automatic test_width();
    logic [7:0] v8, v12;
    pin8  = 8'h00;
    pin12 = 12'h000;
    do_reset();
    bus_wr(gpio_pkg::OFF_DIR1, 8'hFF);
    rd(gpio_pkg::OFF_DIR1, v8, v12);
    checks++; if (v12 !== 8'h0F) begin errors++; $display("FAIL w12_dir1_read: got %h expected 0f", v12); end
    checks++; if (v8 !== 8'h00) begin errors++; $display("FAIL w8_dir1_read: got %h expected 00", v8); end
    checks++; if (poe12 !== 12'hF00) begin errors++; $display("FAIL w12_pin_oe: got %h expected f00", poe12); end
    bus_wr(gpio_pkg::OFF_DIR1, 8'h00);
    bus_wr(gpio_pkg::OFF_RISE_EN1, 8'h04);
    repeat (2) @(negedge clk);
    pin12 = 12'h400;
    repeat (3) @(negedge clk);
    checks++; if (irq12 !== 1'b1) begin errors++; $display("FAIL w12_irq: got %b expected 1", irq12); end
    rd(gpio_pkg::OFF_FLAG1, v8, v12);
    checks++; if (v12 !== 8'h04) begin errors++; $display("FAIL w12_flag1: got %h expected 04", v12); end
    rd(gpio_pkg::OFF_FLAG0, v8, v12);
    checks++; if (v12 !== 8'h00) begin errors++; $display("FAIL w12_flag0: got %h expected 00", v12); end
    rd(gpio_pkg::OFF_DATA1, v8, v12);
    checks++; if (v12 !== 8'h04) begin errors++; $display("FAIL w12_data1: got %h expected 04", v12); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v8, v12;
    int nonzero;
    pin8  = 8'h00;
    pin12 = 12'h000;
    do_reset();
    bus_wr(gpio_pkg::OFF_DIR0, 8'hFF);
    bus_wr(gpio_pkg::OFF_DATA0, 8'hFF);
    checks++; if (pout8 !== 8'hFF) begin errors++; $display("FAIL mid_setup_out: got %h expected ff", pout8); end
    @(negedge clk);
    bus_address = BASE + 24'(gpio_pkg::OFF_DATA0);
    bus_wdata   = 8'h5A;
    bus_write   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pout8 !== 8'h00) begin errors++; $display("FAIL mid_pin_out: got %h expected 00", pout8); end
    checks++; if (poe8 !== 8'h00) begin errors++; $display("FAIL mid_pin_oe: got %h expected 00", poe8); end
    @(negedge clk);
    bus_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nonzero = 0;
    for (int off = 0; off < 16; off++) begin
      rd(4'(off), v8, v12);
      if (v8 !== 8'h00 || v12 !== 8'h00) begin
        nonzero++;
        $display("FAIL mid_read_off%0d: got %h/%h expected 00/00", off, v8, v12);
      end
    end
    checks++; if (nonzero != 0) begin errors++; $display("FAIL mid_reads: got %0d nonzero expected 0", nonzero); end
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", irq8); end
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b0;
    bus_write   = 1'b0;
    bus_read    = 1'b0;
    bus_address = '0;
    bus_wdata   = '0;
    pin8        = '0;
    pin12       = '0;
    checks      = 0;
    errors      = 0;

    test_reset_and_rw();
    test_rise_irq();
    test_w1c_collision();
    test_arming();
    test_output_pin();
    test_width();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised general-purpose I/O port with per-pin direction, output latch, input synchroniser and edge-triggered interrupt flags.
- Replaces the hard-wired 2060/2061 direction/data logic in the SoC top. Sits on the CPU register bus as one more read-data source, OR-combined into the peripheral read mux.
- Drives an interrupt pulse into the irq controller.
- Pins 2/3 keep their existing use as EEPROM data/ce, supplied by the top from pin_out/pin_oe.

Parameters:
- NUM_PINS, 8, number of I/O pins, 1..16; bank count B = ceil(NUM_PINS/8).
- BASE_ADDR, 24'h2060, bus address of offset 0; window is BASE_ADDR..BASE_ADDR+15.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_write  in  1  bus write strobe.
- bus_read  in  1  bus read strobe.
- bus_address_in  in  24  bus address.
- bus_data_in  in  8  bus write data.
- bus_data_out  out  8  read data; 8'h00 when not selected.
- bus_hit  out  1  address inside the window; the top uses it to steer cpu_data_in.
- pin_in  in  NUM_PINS  raw asynchronous pin levels.
- pin_out  out  NUM_PINS  output latch value.
- pin_oe  out  NUM_PINS  1 = pin driven (direction register).
- irq  out  1  one-cycle pulse when any flag goes 0->1.

Behaviour:
- Register map (offset from BASE_ADDR; b = bank 0/1; bits at or above NUM_PINS read 0 and ignore writes):
  - 0x0 DIR0, 0x1 DATA0, 0x2 DIR1, 0x3 DATA1.
  - 0x4 RISE_EN0, 0x5 FALL_EN0, 0x6 RISE_EN1, 0x7 FALL_EN1.
  - 0x8 FLAG0, 0x9 FLAG1.
  - Offsets 0xA..0xF and bank-1 registers when B=1 read 0, writes ignored.
- Writes: committed on the rising edge where bus_write=1 and the address matches. No extra latency. DATA write updates the output latch only.
- DATA read: per bit, the output latch if DIR=1, else the synchronised input (last synchroniser stage).
- FLAG register:
  - Write-1-to-clear.
  - A set and a clear of the same bit in the same cycle: the set wins.
- bus_data_out: combinational from registered state; non-zero only when bus_read=1 and the offset is implemented.
- bus_hit: combinational address compare, independent of strobes.
- Synchroniser: SYNC_STAGES flops per pin, plus a prev flop for edge detection.
- Edge detection (pin with DIR=0 only):
  - Rising edge: prev=0 and sync=1 with RISE_EN=1 -> FLAG set on the next edge.
  - Falling edge: likewise with FALL_EN.
  - Output pins never set flags.
  - DIR 1->0 change: no edge is reported until one full cycle after the change; prev is reloaded on the change.
- Arming counter: after reset deassertion, edge detection is suppressed for SYNC_STAGES+1 cycles. States DISARMED (counting) -> ARMED. During DISARMED the synchroniser and prev still sample.
- Latency: a pin transition becomes visible in DATA after SYNC_STAGES clocks. The flag sets 1 clock after that; irq pulses in the same cycle the flag becomes 1.
- irq:
  - Pulses for exactly 1 cycle when the OR of newly set flag bits is non-zero.
  - Flags that are already set do not re-pulse.
  - Several pins setting together give a single pulse.
- Reset (async, any time, including mid-write):
  - All registers 0; pin_out=0, pin_oe=0, irq=0, bus_data_out=0.
  - Synchronisers and prev cleared; arming counter restarts.

Decomposition:
- gpio_pkg holds:
  - Register offset localparams (OFF_DIR0..OFF_FLAG1).
  - Window size 16.
  - Function bank_count(NUM_PINS).
- Sub-module gpio_sync_edge (parameter SYNC_STAGES), one instance per pin.
  - Inputs: clk, reset, pin_in, armed, dir, rise_en, fall_en.
  - Outputs: sync_level, edge_set.

Test Plan:
- Reset then register write/read: write DIR0=8'hF0, DATA0=8'hA5 with pin_in=8'h0F -> pin_oe=F0, pin_out=A5; read DATA0=8'hAF; read offset 0xA=8'h00; bus_hit=0 at 0x2070.
- Rising-edge IRQ: RISE_EN0=8'h01, DIR0=0, pin_in[0] 0->1 -> DATA0 bit0 visible after 2 clocks; FLAG0=8'h01 with irq high 1 cycle at clock 3; irq stays low afterwards while pin held high.
- W1C vs set collision: FLAG0=8'h01, write FLAG0=8'h03 in the same cycle that pin1's falling edge (FALL_EN0=8'h02) sets bit1 -> FLAG0=8'h02; one irq pulse.
- Arming after reset: pin_in=8'hFF held through reset, RISE_EN0=8'hFF written at cycle 1 -> no flag and no irq.
- Width generalisation: NUM_PINS=12, write DIR1=8'hFF -> reads 8'h0F, pin_oe[11:8]=4'hF; pin 10 rising edge with RISE_EN1=8'h04 -> FLAG1=8'h04.
- Mid-operation reset: assert reset asynchronously between clocks during bus_write to DATA0 -> pin_out=0 immediately; after release, reads of all registers return 0.
